// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM engine: compare modes,
// default widths and the packed channel-config width.
package pwm_pkg;

    localparam logic [1:0] PWM_LEFT  = 2'b00;
    localparam logic [1:0] PWM_RIGHT = 2'b01;
    localparam logic [1:0] PWM_WIN   = 2'b10;
    localparam logic [1:0] PWM_NWIN  = 2'b11;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_PRESC_W  = 8;

    // Packed config layout: {mode[1:0], inv, cmp1, cmp2}
    function automatic int cfg_width(input int cnt_w);
        return 3 + 2 * cnt_w;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: shadow/active config pair, pending flag and a
// registered output computed from the shared counter value.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             load_en_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [1:0]       mode_i,
    input  logic             inv_i,
    input  logic [CNT_W-1:0] cmp1_i,
    input  logic [CNT_W-1:0] cmp2_i,
    output logic             pending_o,
    output logic             pwm_o
);

    localparam int CFG_W = cfg_width(CNT_W);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;

    logic [1:0]       act_mode;
    logic             act_inv;
    logic [CNT_W-1:0] act_cmp1, act_cmp2;
    logic             in_win;
    logic             raw;

    assign {act_mode, act_inv, act_cmp1, act_cmp2} = active_q;

    // A write landing on the load edge leaves the old shadow to be loaded
    // and keeps the new value pending for the following load.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load_en_i && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (wr_en_i) begin
            shadow_d  = {mode_i, inv_i, cmp1_i, cmp2_i};
            pending_d = 1'b1;
        end
    end

    always_comb begin
        in_win = (count_i >= act_cmp1) && (count_i < act_cmp2);
        raw    = 1'b0;
        case (act_mode)
            PWM_LEFT:  raw = count_i < act_cmp1;
            PWM_RIGHT: raw = count_i >= act_cmp1;
            PWM_WIN:   raw = in_win;
            PWM_NWIN:  raw = !in_win;
            default:   raw = 1'b0;
        endcase
        pwm_d = run_i ? (raw ^ act_inv) : act_inv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pending_o = pending_q;
    assign pwm_o     = pwm_q;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM engine: shared prescaler and period counter driving
// CHANNELS double-buffered compare channels.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int CNT_W    = DEF_CNT_W,
    parameter  int PRESC_W  = DEF_PRESC_W,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pwm_en,
    input  logic                cnt_clr,
    input  logic [CNT_W-1:0]    period,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic                cfg_inv,
    input  logic [CNT_W-1:0]    cfg_cmp1,
    input  logic [CNT_W-1:0]    cfg_cmp2,
    output logic [CNT_W-1:0]    count_val,
    output logic                period_done,
    output logic [CHANNELS-1:0] cfg_pending,
    output logic [CHANNELS-1:0] pwm_out
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q;
    logic               tick;
    logic               wrap;
    logic               load_en;

    assign tick = (presc_q == prescale) && pwm_en;

    // Rolling over from all-ones counts as a wrap so a period lowered
    // below the running count still produces a clean period boundary.
    assign wrap    = tick && !cnt_clr && ((cnt_q == period) || (cnt_q == {CNT_W{1'b1}}));
    assign load_en = wrap || !pwm_en;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            presc_d = '0;
            cnt_d   = (cnt_q == period) ? '0 : cnt_q + CNT_W'(1);
        end else if (pwm_en) begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            done_q  <= wrap;
        end
    end

    assign count_val   = cnt_q;
    assign period_done = done_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en_i   (cfg_wr && (int'(cfg_ch) == i)),
            .load_en_i (load_en),
            .run_i     (pwm_en),
            .count_i   (cnt_q),
            .mode_i    (cfg_mode),
            .inv_i     (cfg_inv),
            .cmp1_i    (cfg_cmp1),
            .cmp2_i    (cfg_cmp2),
            .pending_o (cfg_pending[i]),
            .pwm_o     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed scenarios plus random
// traffic, compared each cycle against a behavioural model.
module tb_pwm_multi_gen;

    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int PW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm_en, cnt_clr, cfg_wr, cfg_inv;
    logic [CW-1:0] period, cfg_cmp1, cfg_cmp2, count_val;
    logic [PW-1:0] prescale;
    logic [1:0]    cfg_ch, cfg_mode;
    logic          period_done;
    logic [CH-1:0] cfg_pending, pwm_out;

    int checks = 0;
    int errors = 0;

    int m_cnt, m_presc;
    bit m_pd;
    bit m_pend[CH], m_pwm[CH];
    int sh_mode[CH], sh_c1[CH], sh_c2[CH], ac_mode[CH], ac_c1[CH], ac_c2[CH];
    bit sh_inv[CH], ac_inv[CH];

    pwm_multi_gen #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .cnt_clr(cnt_clr),
        .period(period), .prescale(prescale), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_inv(cfg_inv), .cfg_cmp1(cfg_cmp1), .cfg_cmp2(cfg_cmp2),
        .count_val(count_val), .period_done(period_done),
        .cfg_pending(cfg_pending), .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit raw_of(input int mode, input int c, input int c1, input int c2);
        case (mode)
            0:       return c < c1;
            1:       return c >= c1;
            2:       return (c >= c1) && (c < c2);
            default: return !((c >= c1) && (c < c2));
        endcase
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_presc = 0; m_pd = 0;
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = 0; m_pwm[i] = 0;
            sh_mode[i] = 0; sh_c1[i] = 0; sh_c2[i] = 0; sh_inv[i] = 0;
            ac_mode[i] = 0; ac_c1[i] = 0; ac_c2[i] = 0; ac_inv[i] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, using current inputs.
    task automatic m_step();
        bit tick, wrap, load;
        int nc, np;
        for (int i = 0; i < CH; i++)
            m_pwm[i] = pwm_en ? (raw_of(ac_mode[i], m_cnt, ac_c1[i], ac_c2[i]) ^ ac_inv[i]) : ac_inv[i];
        tick = pwm_en && (m_presc == int'(prescale));
        wrap = !cnt_clr && tick && (m_cnt == int'(period) || m_cnt == CMAX);
        if (cnt_clr) begin
            nc = 0; np = 0;
        end else if (tick) begin
            np = 0;
            nc = (m_cnt == int'(period)) ? 0 : (m_cnt + 1) % (CMAX + 1);
        end else begin
            nc = m_cnt;
            np = pwm_en ? (m_presc + 1) % (PMAX + 1) : m_presc;
        end
        load = wrap || !pwm_en;
        for (int i = 0; i < CH; i++)
            if (load && m_pend[i]) begin
                ac_mode[i] = sh_mode[i]; ac_inv[i] = sh_inv[i];
                ac_c1[i] = sh_c1[i]; ac_c2[i] = sh_c2[i];
                m_pend[i] = 0;
            end
        if (cfg_wr) begin
            sh_mode[cfg_ch] = int'(cfg_mode); sh_inv[cfg_ch] = cfg_inv;
            sh_c1[cfg_ch] = int'(cfg_cmp1); sh_c2[cfg_ch] = int'(cfg_cmp2);
            m_pend[cfg_ch] = 1;
        end
        m_pd = wrap; m_cnt = nc; m_presc = np;
    endtask

    task automatic compare_all();
        logic [CH-1:0] pend_v, pwm_v;
        for (int i = 0; i < CH; i++) begin
            pend_v[i] = m_pend[i];
            pwm_v[i]  = m_pwm[i];
        end
        chk("count", 32'(count_val), 32'(m_cnt));
        chk("pdone", 32'(period_done), 32'(m_pd));
        chk("pending", 32'(cfg_pending), 32'(pend_v));
        chk("pwm", 32'(pwm_out), 32'(pwm_v));
    endtask

    task automatic cycle();
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input int ch, input int mode, input bit inv, input int c1, input int c2);
        cfg_wr = 1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_inv = inv;
        cfg_cmp1 = CW'(c1); cfg_cmp2 = CW'(c2);
        cycle();
        cfg_wr = 0;
    endtask

    // Runs until the model reports a period_done; expiry counts as a failure.
    task automatic run_to_wrap(input string tag, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!period_done && n < budget);
        if (!period_done) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int hi, pd, lo;
        rst_n = 0; pwm_en = 0; cnt_clr = 0; cfg_wr = 0; cfg_ch = 0; cfg_mode = 0;
        cfg_inv = 0; cfg_cmp1 = 0; cfg_cmp2 = 0; period = 0; prescale = 0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        compare_all();

        // Basic left-aligned duty: 3 of 10 high, period_done every 10 clk
        period = 9; prescale = 0;
        wr(0, 0, 0, 3, 0);
        wr(3, 0, 0, 0, 0);
        cycle();
        pwm_en = 1;
        hi = 0; pd = 0;
        repeat (20) begin
            cycle();
            hi += int'(pwm_out[0]); pd += int'(period_done);
        end
        chk("duty_ch0", 32'(hi), 6);
        chk("pdone_10", 32'(pd), 2);

        // Mid-period shadow write: pending until wrap, then applied
        repeat (3) cycle();
        wr(1, 0, 0, 7, 0);
        chk("pend1_set", 32'(cfg_pending[1]), 1);
        run_to_wrap("p1", 40);
        chk("pend1_clr", 32'(cfg_pending[1]), 0);

        // Inverted window on ch2: low exactly for counts 2..4
        wr(2, 2, 1, 2, 5);
        wr(0, 1, 0, 0, 0);
        run_to_wrap("p2", 40);
        lo = 0;
        repeat (10) begin
            cycle();
            lo += int'(!pwm_out[2]);
        end
        chk("win_low", 32'(lo), 3);

        // Prescale 2, period 4: period_done every 15 clk
        prescale = 2; period = 4;
        cnt_clr = 1; cycle(); cnt_clr = 0;
        pd = 0;
        repeat (30) begin
            cycle();
            pd += int'(period_done);
        end
        chk("pdone_15", 32'(pd), 2);

        // Write landing exactly on the wrap edge
        prescale = 0; period = 9;
        for (int n = 0; n < 30 && !(m_cnt == 9); n++) cycle();
        wr(1, 1, 1, 4, 0);
        chk("wrapwr_pend", 32'(cfg_pending[1]), 1);
        run_to_wrap("p3", 40);
        chk("wrapwr_pend2", 32'(cfg_pending[1]), 0);

        // Disable mid-period: freeze, idle levels, write applies next clk
        repeat (4) cycle();
        pwm_en = 0;
        repeat (3) cycle();
        wr(3, 0, 1, 2, 0);
        cycle();
        chk("en0_pend", 32'(cfg_pending[3]), 0);
        pwm_en = 1;

        // Period lowered below the running count: roll over through all-ones
        period = 200;
        for (int n = 0; n < 200 && m_cnt < 100; n++) cycle();
        period = 50;
        run_to_wrap("roll", 400);

        // Async reset mid-period
        repeat (3) cycle();
        #2 rst_n = 0;
        #1;
        chk("rst_cnt", 32'(count_val), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_pend", 32'(cfg_pending), 0);
        @(negedge clk);
        rst_n = 1;
        m_reset();
        compare_all();

        // Random traffic
        period = 9;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0) period = CW'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) prescale = PW'($urandom_range(0, 2));
            pwm_en  = $urandom_range(0, 9) != 0;
            cnt_clr = $urandom_range(0, 32) == 0;
            cfg_wr  = $urandom_range(0, 3) == 0;
            cfg_ch  = 2'($urandom_range(0, CH - 1));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_inv  = 1'($urandom_range(0, 1));
            cfg_cmp1 = ($urandom_range(0, 15) == 0) ? CW'(CMAX) : CW'($urandom_range(0, 17));
            cfg_cmp2 = CW'($urandom_range(0, 17));
            cycle();
        end
        cfg_wr = 0; cnt_clr = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
